// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and arbitration mode constants used by the
// multi-master arbiter and its winner selector.
package ahb_pkg;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'd0,
    HSIZE_HALFWORD = 3'd1,
    HSIZE_WORD     = 3'd2
  } hsize_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/ahb_arb_select.sv
// Combinational winner picker: scans requesters starting just after a base
// index with wrap-around. Fixed priority is the same scan anchored at index 0.
module ahb_arb_select
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = ARB_FIXED,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       owner_i,
  output logic [IDX_W-1:0]       win_o,
  output logic                   valid_o
);

  int base;
  int idx;

  always_comb begin
    win_o   = '0;
    valid_o = |req_i;
    idx     = 0;
    // Fixed priority starts the scan from NUM_MASTERS-1 so index 0 comes first.
    base    = (ARB_MODE == ARB_RR) ? int'(owner_i) : NUM_MASTERS - 1;
    // Walk the search order backwards so the earliest requester is written last.
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (base + k) % NUM_MASTERS;
      if (req_i[idx]) win_o = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/ahb_multi_master_arbiter.sv
// N-master AHB-lite arbiter/mux: address-phase owner drives the bus control,
// data-phase owner follows one accepted transfer behind and steers hwdata/hresp.
module ahb_multi_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                              clk_i,
  input  logic                              resetn_i,
  input  logic [NUM_MASTERS-1:0]            req_i,
  input  logic [NUM_MASTERS-1:0]            lock_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata_i,
  input  logic [NUM_MASTERS*3-1:0]          m_hsize_i,
  input  logic [NUM_MASTERS*2-1:0]          m_htrans_i,
  input  logic [NUM_MASTERS-1:0]            m_hwrite_i,
  output logic [DATA_WIDTH-1:0]             m_hrdata_o,
  output logic [NUM_MASTERS-1:0]            m_hready_o,
  output logic [NUM_MASTERS*2-1:0]          m_hresp_o,
  output logic [ADDR_WIDTH-1:0]             haddr_o,
  output logic [DATA_WIDTH-1:0]             hwdata_o,
  output logic [2:0]                        hsize_o,
  output logic [1:0]                        htrans_o,
  output logic                              hwrite_o,
  input  logic [DATA_WIDTH-1:0]             hrdata_i,
  input  logic                              hready_i,
  input  logic [1:0]                        hresp_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

  logic [IDX_W-1:0] addr_owner_q, addr_owner_d;
  logic [IDX_W-1:0] data_owner_q, data_owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  ahb_arb_select #(
    .NUM_MASTERS(NUM_MASTERS),
    .ARB_MODE   (ARB_MODE),
    .IDX_W      (IDX_W)
  ) u_select (
    .req_i  (req_i),
    .owner_i(rr_ptr_q),
    .win_o  (sel_idx),
    .valid_o(sel_valid)
  );

  // Handshake: a transfer phase is accepted only on an edge with hready_i=1;
  // every owner/pipeline update happens on such edges and nowhere else.
  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    rr_ptr_d     = rr_ptr_q;
    if (hready_i) begin
      data_owner_d = addr_owner_q;
      if (req_i[addr_owner_q] && (lock_i[addr_owner_q] || ARB_MODE == ARB_RR)) begin
        addr_owner_d = addr_owner_q;
      end else if (sel_valid) begin
        addr_owner_d = sel_idx;
      end else begin
        addr_owner_d = DEF_IDX;
      end
      // Tracking the owner keeps the next search starting at owner+1.
      if (ARB_MODE == ARB_RR) rr_ptr_d = addr_owner_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      addr_owner_q <= DEF_IDX;
      data_owner_q <= DEF_IDX;
      rr_ptr_q     <= DEF_IDX;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_comb begin
    grant_o    = '0;
    m_hready_o = '0;
    m_hresp_o  = '0;
    haddr_o    = '0;
    hwdata_o   = '0;
    hsize_o    = '0;
    htrans_o   = '0;
    hwrite_o   = 1'b0;
    m_hrdata_o = hrdata_i;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (IDX_W'(i) == addr_owner_q) begin
        grant_o[i] = 1'b1;
        haddr_o    = m_haddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        hsize_o    = m_hsize_i[i*3 +: 3];
        htrans_o   = m_htrans_i[i*2 +: 2];
        hwrite_o   = m_hwrite_i[i];
      end
      if (IDX_W'(i) == data_owner_q) begin
        hwdata_o          = m_hwdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_hresp_o[i*2 +: 2] = hresp_i;
      end else begin
        m_hresp_o[i*2 +: 2] = HRESP_OKAY;
      end
      m_hready_o[i] = hready_i && (IDX_W'(i) == addr_owner_q || IDX_W'(i) == data_owner_q);
    end
  end

endmodule
